// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the debounce bank.
// Optional long-press support is enabled with DEBOUNCE_HOLD_EN.
package debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
    localparam int DEFAULT_HOLD_LIMIT     = 25000000;

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: 2-flop synchroniser, stability counter, level and edge pulses.
// With DEBOUNCE_HOLD_EN a long-press counter drives o_Hold.
import debounce_pkg::*;

module debounce_channel #(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
`ifdef DEBOUNCE_HOLD_EN
    parameter int HOLD_LIMIT = DEFAULT_HOLD_LIMIT,
`endif
    parameter logic RESET_BIT = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise,
    output logic o_Fall,
`ifdef DEBOUNCE_HOLD_EN
    output logic o_Hold,
`endif
    output logic o_Commit
);

    localparam int CNT_W = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync_q;
    logic             s;
    logic [CNT_W-1:0] cnt;

    // Combinational so the bank can register o_Any_Change alongside the pulses.
    assign o_Commit = (s != o_Switch) && (cnt == CNT_LAST);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q   <= RESET_BIT;
            s        <= RESET_BIT;
            o_Switch <= RESET_BIT;
            cnt      <= '0;
            o_Rise   <= 1'b0;
            o_Fall   <= 1'b0;
        end else begin
            sync_q <= i_Switch;
            s      <= sync_q;
            o_Rise <= o_Commit && s;
            o_Fall <= o_Commit && !s;
            if (s == o_Switch) begin
                cnt <= '0;
            end else if (o_Commit) begin
                cnt      <= '0;
                o_Switch <= s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef DEBOUNCE_HOLD_EN
    localparam int HOLD_W = cnt_width(HOLD_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LIMIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(HOLD_LIMIT);

    logic [HOLD_W-1:0] hold_cnt;

    // Parks at HOLD_DONE so a long press pulses once until released.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hold_cnt <= '0;
            o_Hold   <= 1'b0;
        end else begin
            o_Hold <= o_Switch && (hold_cnt == HOLD_LAST);
            if (!o_Switch) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_DONE) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end
`endif

endmodule

// File: rtl/debounce_bank.sv
// N-channel switch debouncer with per-channel edge pulses and a shared change flag.
// Define DEBOUNCE_HOLD_EN to add the o_Hold long-press output.
import debounce_pkg::*;

module debounce_bank #(
    parameter int NUM_CH = 4,
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
`ifdef DEBOUNCE_HOLD_EN
    parameter int HOLD_LIMIT = DEFAULT_HOLD_LIMIT,
`endif
    parameter logic [NUM_CH-1:0] RESET_VALUE = '0
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Switch,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
`ifdef DEBOUNCE_HOLD_EN
    output logic [NUM_CH-1:0] o_Hold,
`endif
    output logic              o_Any_Change
);

    logic [NUM_CH-1:0] commit;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
`ifdef DEBOUNCE_HOLD_EN
            .HOLD_LIMIT    (HOLD_LIMIT),
`endif
            .RESET_BIT     (RESET_VALUE[i])
        ) u_ch (
            .i_Clk   (i_Clk),
            .i_Rst_L (i_Rst_L),
            .i_Switch(i_Switch[i]),
            .o_Switch(o_Switch[i]),
            .o_Rise  (o_Rise[i]),
            .o_Fall  (o_Fall[i]),
`ifdef DEBOUNCE_HOLD_EN
            .o_Hold  (o_Hold[i]),
`endif
            .o_Commit(commit[i])
        );
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Any_Change <= 1'b0;
        end else begin
            o_Any_Change <= |commit;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank against a window-based reference model.
// Covers the o_Hold path when built with DEBOUNCE_HOLD_EN.
module tb_debounce_bank;

    localparam int N    = 4;
    localparam int LIM  = 4;
    localparam int HOLD = 10;
    localparam logic [N-1:0] RV = 4'b0101;

    logic         i_Clk = 1'b0;
    logic         i_Rst_L = 1'b1;
    logic [N-1:0] i_Switch = RV;
    logic [N-1:0] o_Switch, o_Rise, o_Fall;
    logic         o_Any_Change;
`ifdef DEBOUNCE_HOLD_EN
    logic [N-1:0] o_Hold;
`endif

    int n_cmp = 0;
    int n_err = 0;

    debounce_bank #(
        .NUM_CH        (N),
        .DEBOUNCE_LIMIT(LIM),
`ifdef DEBOUNCE_HOLD_EN
        .HOLD_LIMIT    (HOLD),
`endif
        .RESET_VALUE   (RV)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Switch    (i_Switch),
        .o_Switch    (o_Switch),
        .o_Rise      (o_Rise),
        .o_Fall      (o_Fall),
`ifdef DEBOUNCE_HOLD_EN
        .o_Hold      (o_Hold),
`endif
        .o_Any_Change(o_Any_Change)
    );

    always #5 i_Clk = ~i_Clk;

    // Reference: a level flips once the last LIM synchronised samples all differ
    // from it; s lags the raw input by two edges; hold fires HOLD cycles after going high.
    logic [N-1:0] m_lvl, m_rise, m_fall, m_hold, m_in_prev;
    logic [N-1:0] s_q[$];
    int cyc;
    int hi_since[N];

    always @(posedge i_Clk or negedge i_Rst_L) begin : model
        logic [N-1:0] old;
        bit all_diff;
        if (!i_Rst_L) begin
            m_lvl = RV; m_rise = '0; m_fall = '0; m_hold = '0;
            m_in_prev = RV; s_q.delete(); cyc = 0;
            for (int c = 0; c < N; c++) hi_since[c] = 0;
        end else begin
            old = m_lvl;
            cyc++;
            m_rise = '0; m_fall = '0; m_hold = '0;
            for (int c = 0; c < N; c++) begin
                all_diff = (s_q.size() >= LIM);
                for (int k = 0; k < LIM; k++)
                    if (all_diff && s_q[s_q.size() - 1 - k][c] == old[c])
                        all_diff = 0;
                if (old[c] && (cyc - hi_since[c] == HOLD)) m_hold[c] = 1'b1;
                if (all_diff) begin
                    m_lvl[c] = ~old[c];
                    if (!old[c]) begin
                        m_rise[c] = 1'b1;
                        hi_since[c] = cyc;
                    end else begin
                        m_fall[c] = 1'b1;
                    end
                end
            end
            s_q.push_back(m_in_prev);
            if (s_q.size() > LIM) void'(s_q.pop_front());
            m_in_prev = i_Switch;
        end
    end

    task automatic tick;
        @(posedge i_Clk);
        @(negedge i_Clk);
    endtask

    task automatic test_reset;
        i_Switch = RV;
        @(negedge i_Clk);
        i_Rst_L = 1'b0;
        repeat (3) tick();
        i_Rst_L = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_cmp++;
            if (o_Switch !== RV || o_Rise !== '0 || o_Fall !== '0 || o_Any_Change !== 1'b0) begin
                n_err++;
                $display("FAIL reset k=%0d sw=%b rise=%b fall=%b any=%b want sw=%b and no pulses",
                         k, o_Switch, o_Rise, o_Fall, o_Any_Change, RV);
            end
`ifdef DEBOUNCE_HOLD_EN
            n_cmp++;
            if (o_Hold !== m_hold) begin
                n_err++;
                $display("FAIL reset_hold k=%0d got=%b want=%b", k, o_Hold, m_hold);
            end
`endif
        end
    endtask

    task automatic test_clean_step;
        i_Switch[0] = 1'b0;
        repeat (12) tick();
        i_Switch[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++;
            if (o_Switch[0] !== (k >= 6) || o_Rise[0] !== (k == 6) || o_Any_Change !== (k == 6)) begin
                n_err++;
                $display("FAIL clean_step k=%0d sw0=%b rise0=%b any=%b want sw0=%b rise/any=%b",
                         k, o_Switch[0], o_Rise[0], o_Any_Change, k >= 6, k == 6);
            end
        end
    endtask

    task automatic test_bounce;
        logic [4:0] pat;
        int rises, first;
        pat = 5'b01101;
        rises = 0; first = 0;
        for (int k = 1; k <= 20; k++) begin
            i_Switch[1] = (k <= 5) ? pat[k-1] : 1'b1;
            tick();
            if (o_Rise[1] === 1'b1) begin
                rises++;
                if (first == 0) first = k;
            end
            n_cmp++;
            if (o_Switch[1] !== (k >= 11)) begin
                n_err++;
                $display("FAIL bounce_level k=%0d got=%b want=%b", k, o_Switch[1], k >= 11);
            end
        end
        n_cmp++;
        if (rises != 1 || first != 11) begin
            n_err++;
            $display("FAIL bounce_pulse rises=%0d first=%0d want rises=1 first=11", rises, first);
        end
    endtask

    task automatic test_simultaneous;
        int anys;
        anys = 0;
        i_Switch[2] = 1'b0;
        i_Switch[3] = 1'b1;
        repeat (12) tick();
        i_Switch[2] = 1'b1;
        i_Switch[3] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (o_Any_Change === 1'b1) anys++;
            n_cmp++;
            if (o_Rise[2] !== (k == 6) || o_Fall[3] !== (k == 6) ||
                o_Fall[2] !== 1'b0 || o_Rise[3] !== 1'b0 || o_Any_Change !== (k == 6)) begin
                n_err++;
                $display("FAIL simultaneous k=%0d rise=%b fall=%b any=%b want pulses=%b",
                         k, o_Rise, o_Fall, o_Any_Change, k == 6);
            end
        end
        n_cmp++;
        if (anys != 1) begin
            n_err++;
            $display("FAIL simultaneous_any count=%0d want=1", anys);
        end
    endtask

    task automatic test_reset_mid;
        i_Switch[0] = 1'b0;
        repeat (4) tick();
        i_Rst_L = 1'b0;
        #1;
        n_cmp++;
        if (o_Switch !== RV || o_Rise !== '0 || o_Fall !== '0 || o_Any_Change !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid sw=%b rise=%b fall=%b any=%b want sw=%b no pulses",
                     o_Switch, o_Rise, o_Fall, o_Any_Change, RV);
        end
        repeat (3) tick();
        i_Rst_L = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++;
            if (o_Switch[0] !== (k < 6) || o_Fall[0] !== (k == 6)) begin
                n_err++;
                $display("FAIL reset_mid_relimit k=%0d sw0=%b fall0=%b want sw0=%b fall0=%b",
                         k, o_Switch[0], o_Fall[0], k < 6, k == 6);
            end
        end
    endtask

    task automatic test_random;
        int rate;
        for (int k = 0; k < 1200; k++) begin
            rate = ((k / 100) % 2 == 0) ? 3 : 12;
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, rate - 1) == 0) i_Switch[c] = ~i_Switch[c];
            if (k == 600) i_Rst_L = 1'b0;
            if (k == 603) i_Rst_L = 1'b1;
            tick();
            n_cmp++;
            if (o_Switch !== m_lvl || o_Rise !== m_rise || o_Fall !== m_fall ||
                o_Any_Change !== |(m_rise | m_fall)) begin
                n_err++;
                $display("FAIL random k=%0d sw=%b/%b rise=%b/%b fall=%b/%b any=%b/%b (got/want)",
                         k, o_Switch, m_lvl, o_Rise, m_rise, o_Fall, m_fall,
                         o_Any_Change, |(m_rise | m_fall));
            end
`ifdef DEBOUNCE_HOLD_EN
            n_cmp++;
            if (o_Hold !== m_hold) begin
                n_err++;
                $display("FAIL random_hold k=%0d got=%b want=%b", k, o_Hold, m_hold);
            end
`endif
        end
    endtask

`ifdef DEBOUNCE_HOLD_EN
    task automatic test_hold;
        int r;
        r = 0;
        i_Switch[0] = 1'b0;
        repeat (20) tick();
        i_Switch[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (o_Rise[0] === 1'b1 && r == 0) r = k;
            n_cmp++;
            if (o_Hold[0] !== (r > 0 && k == r + HOLD)) begin
                n_err++;
                $display("FAIL hold k=%0d got=%b want=%b rise_at=%0d",
                         k, o_Hold[0], r > 0 && k == r + HOLD, r);
            end
        end
        n_cmp++;
        if (r != 6) begin
            n_err++;
            $display("FAIL hold_rise_at got=%0d want=6", r);
        end
    endtask
`endif

    initial begin
        #2 i_Rst_L = 1'b0;
        test_reset();
        test_clean_step();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
`ifdef DEBOUNCE_HOLD_EN
        test_hold();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised N-channel successor to the single-switch debouncer.
- Each channel gets a 2-flop synchroniser, a counter that confirms stability for a set number of cycles, the debounced level, and one-cycle rise/fall pulses.
- Sits between raw board inputs (switches, buttons) and control logic.
- The clock rate and debounce window are parameters; counter width is derived, not fixed.

Parameters:
- NUM_CH, 4, number of independent channels (1..32).
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles required to accept a new level (>=2); 10 ms at 25 MHz.
- CNT_W, $clog2(DEBOUNCE_LIMIT+1), counter width; derived, not overridden.
- RESET_VALUE, {NUM_CH{1'b0}}, per-channel level loaded at reset.
- HOLD_LIMIT, 25000000, cycles of stable asserted level before a hold pulse; used only with the optional feature.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_Switch  in  NUM_CH  raw, asynchronous switch inputs
- o_Switch  out  NUM_CH  debounced levels
- o_Rise  out  NUM_CH  one-cycle pulse when the debounced level goes 0->1
- o_Fall  out  NUM_CH  one-cycle pulse when the debounced level goes 1->0
- o_Any_Change  out  1  OR of all o_Rise and o_Fall bits, registered with them
- o_Hold  out  NUM_CH  one-cycle long-press pulse; exists only under DEBOUNCE_HOLD_EN

Behaviour:
- Reset:
  - Asynchronous, active-low; the clock is one domain, i_Clk.
  - Sync flops and o_Switch load RESET_VALUE.
  - Counters, o_Rise, o_Fall, o_Any_Change and o_Hold clear to 0.
  - No edge pulse is produced on reset release.
- Synchroniser:
  - Two flops per channel.
  - s = second-stage output; later logic sees only s.
- Per-channel counter, evaluated each cycle:
  - s == o_Switch: cnt <= 0.
  - s != o_Switch and cnt < DEBOUNCE_LIMIT-1: cnt <= cnt+1.
  - s != o_Switch and cnt == DEBOUNCE_LIMIT-1: o_Switch <= s, cnt <= 0, and the matching o_Rise/o_Fall bit is set for exactly the next cycle.
  - Net effect: a new level is accepted after exactly DEBOUNCE_LIMIT consecutive differing cycles of s.
- Glitch rule:
  - Any single cycle where s matches o_Switch restarts the count from 0.
  - The count never saturates or wraps.
- Latency:
  - Clean step on i_Switch -> o_Switch changes DEBOUNCE_LIMIT+2 cycles later.
  - o_Rise/o_Fall are high in the same cycle that o_Switch first shows the new value.
- Edge pulses:
  - Each pulse lasts exactly 1 cycle.
  - o_Rise and o_Fall are never both high on one channel.
- Multiple channels:
  - Channels are fully independent; simultaneous commits on several channels all pulse in the same cycle.
  - o_Any_Change is high for that one cycle only.
- Reset mid-count: the count is discarded and o_Switch returns to RESET_VALUE.

Optional Feature:
- Macro: DEBOUNCE_HOLD_EN.
- Defined:
  - Each channel gets a second counter, width $clog2(HOLD_LIMIT+1).
  - The counter increments while o_Switch == 1 and clears when o_Switch == 0.
  - When it reaches HOLD_LIMIT-1, o_Hold pulses for one cycle and the counter stops; it does not repeat until o_Switch falls and rises again.
  - The counter and o_Hold reset to 0.
- Undefined:
  - The o_Hold port and hold counters are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package debounce_pkg holds:
  - Default DEBOUNCE_LIMIT and HOLD_LIMIT constants.
  - A clog2-based width helper for CNT_W.
- Natural sub-module: debounce_channel (synchroniser, counter, level register, edge pulses, optional hold counter) for one channel.
- debounce_bank generates NUM_CH instances and the o_Any_Change OR-reduce register.

Test Plan:
- Reset: NUM_CH=4, LIMIT=4, RESET_VALUE=4'b0101, hold i_Switch=4'b0101 through reset release -> o_Switch=4'b0101; o_Rise, o_Fall and o_Any_Change stay 0 for 20 cycles.
- Clean step: LIMIT=4, ch0 0->1 at cycle T -> o_Switch[0]=1 first at T+6; o_Rise[0]=1 only at T+6; o_Any_Change=1 only at T+6.
- Bounce: LIMIT=4, ch1 toggles 1,0,1,1,0 on successive cycles, then holds 1 -> no change until 4 stable cycles of s; exactly one o_Rise[1] pulse.
- Simultaneous: ch2 rises and ch3 falls in the same cycle -> o_Rise[2] and o_Fall[3] pulse in the same cycle; one o_Any_Change pulse.
- Reset mid-count: assert i_Rst_L=0 when cnt=2 -> o_Switch returns to RESET_VALUE, no pulse; after release a full LIMIT is needed again.
- Hold (DEBOUNCE_HOLD_EN, HOLD_LIMIT=10): ch0 held high -> one o_Hold[0] pulse 10 cycles after the o_Rise[0] cycle, none after that.
